// File: rtl/grid_state_manager.sv
// grid_state_manager
//
// Purpose:
//   Owns the kitchen game state that the renderer draws: an 8x13 grid of
//   4-bit object codes and a set of chopping-timer slots. Game logic edits
//   a working copy one cell at a time over a valid/ready handshake. Once
//   per frame, when vsync falls, the working copy is committed to a display
//   copy, so the renderer never sees a half-applied update. Every
//   FRAMES_PER_STEP frames, each active timer counts down by one. When a
//   timer expires, the object in its cell advances by one code.
//
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   vsync              XVGA vertical sync (active low)
//   req_valid/ready    request handshake
//   req_op             0 WRITE, 1 START_TIMER, 2 CANCEL_TIMER, 3 CLEAR_ALL
//   req_row/col/value  target cell and object code or timer steps
//   resp_valid/ok      one-cycle completion pulse and accept/reject flag
//   object_grid        committed object codes, [row][col]
//   time_grid          committed remaining steps per slot, 0 = free
//   done_mask          one-cycle pulse per slot that expired
module grid_state_manager #(
    parameter int FRAMES_PER_STEP = 60,
    parameter int NUM_SLOTS       = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      vsync,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [2:0]                req_row,
    input  logic [3:0]                req_col,
    input  logic [3:0]                req_value,
    output logic                      resp_valid,
    output logic                      resp_ok,
    output logic [7:0][12:0][3:0]     object_grid,
    output logic [NUM_SLOTS-1:0][3:0] time_grid,
    output logic [NUM_SLOTS-1:0]      done_mask
);

    localparam int          SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [15:0] PRE_LAST = 16'(FRAMES_PER_STEP - 1);

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_START  = 2'd1;
    localparam logic [1:0] OP_CANCEL = 2'd2;

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t                    state_q;
    logic                      vsync_q;
    logic                      frameTick_q;
    logic [15:0]               preCnt_q;
    logic [15:0]               preCnt_d;
    logic [7:0][12:0][3:0]     workGrid_q;
    logic [7:0][12:0][3:0]     dispGrid_q;
    logic [NUM_SLOTS-1:0][3:0] slotTime_q;
    logic [NUM_SLOTS-1:0][3:0] dispTime_q;
    logic [NUM_SLOTS-1:0][2:0] slotRow_q;
    logic [NUM_SLOTS-1:0][3:0] slotCol_q;
    logic [2:0]                clrRow_q;
    logic [3:0]                clrCol_q;
    logic                      respValid_q;
    logic                      respOk_q;
    logic [NUM_SLOTS-1:0]      doneMask_q;

    logic                      step;
    logic                      accept;
    logic                      hitFound;
    logic                      freeFound;
    logic [SW-1:0]             hitIdx;
    logic [SW-1:0]             freeIdx;

    // A step is the frame tick on which the prescaler wraps. During that
    // cycle the timers own the working grid, so requests are held off.
    assign step      = frameTick_q && (preCnt_q == PRE_LAST);
    assign req_ready = !reset && (state_q == IDLE) && !step;
    assign accept    = req_valid && req_ready;

    assign preCnt_d  = !frameTick_q         ? preCnt_q :
                       (preCnt_q == PRE_LAST) ? 16'd0 : preCnt_q + 16'd1;

    assign object_grid = dispGrid_q;
    assign time_grid   = dispTime_q;
    assign resp_valid  = respValid_q;
    assign resp_ok     = respOk_q;
    assign done_mask   = doneMask_q;

    // Slot lookup for the current request. The search runs from the top
    // index down, so the lowest matching index wins. A cell is never held by
    // two active slots, because START reloads an existing slot first.
    always_comb begin
        hitFound  = 1'b0;
        freeFound = 1'b0;
        hitIdx    = '0;
        freeIdx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slotTime_q[i] != 4'd0 && slotRow_q[i] == req_row && slotCol_q[i] == req_col) begin
                hitFound = 1'b1;
                hitIdx   = SW'(i);
            end
            if (slotTime_q[i] == 4'd0) begin
                freeFound = 1'b1;
                freeIdx   = SW'(i);
            end
        end
    end

    // All sequential state, including the IDLE/CLEARING controller.
    // The commit samples the working registers before this cycle's
    // non-blocking updates land, which is exactly the pre-update snapshot the
    // display needs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b0;
            frameTick_q <= 1'b0;
            preCnt_q    <= '0;
            workGrid_q  <= '0;
            dispGrid_q  <= '0;
            slotTime_q  <= '0;
            dispTime_q  <= '0;
            slotRow_q   <= '0;
            slotCol_q   <= '0;
            clrRow_q    <= '0;
            clrCol_q    <= '0;
            respValid_q <= 1'b0;
            respOk_q    <= 1'b0;
            doneMask_q  <= '0;
        end else begin
            vsync_q     <= vsync;
            frameTick_q <= vsync_q && !vsync;
            preCnt_q    <= preCnt_d;
            respValid_q <= 1'b0;
            respOk_q    <= 1'b0;
            doneMask_q  <= '0;

            // The display freezes during a sweep so that a half-cleared grid
            // is never shown.
            if (frameTick_q && state_q != CLEARING) begin
                dispGrid_q <= workGrid_q;
                dispTime_q <= slotTime_q;
            end

            // Timer countdown. On expiry, the slot's cell advances one object
            // code, saturating at 15. Slots are all free during a sweep, so
            // this loop does nothing then.
            if (step) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (slotTime_q[i] != 4'd0) begin
                        slotTime_q[i] <= slotTime_q[i] - 4'd1;
                        if (slotTime_q[i] == 4'd1) begin
                            doneMask_q[i] <= 1'b1;
                            if (workGrid_q[slotRow_q[i]][slotCol_q[i]] != 4'hF) begin
                                workGrid_q[slotRow_q[i]][slotCol_q[i]] <=
                                    workGrid_q[slotRow_q[i]][slotCol_q[i]] + 4'd1;
                            end
                        end
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_col > 4'd12) begin
                            respValid_q <= 1'b1;
                            respOk_q    <= 1'b0;
                        end else begin
                            case (req_op)
                                OP_WRITE: begin
                                    workGrid_q[req_row][req_col] <= req_value;
                                    respValid_q <= 1'b1;
                                    respOk_q    <= 1'b1;
                                end
                                OP_START: begin
                                    respValid_q <= 1'b1;
                                    if (req_value == 4'd0) begin
                                        respOk_q <= 1'b0;
                                    end else if (hitFound) begin
                                        slotTime_q[hitIdx] <= req_value;
                                        respOk_q           <= 1'b1;
                                    end else if (freeFound) begin
                                        slotTime_q[freeIdx] <= req_value;
                                        slotRow_q[freeIdx]  <= req_row;
                                        slotCol_q[freeIdx]  <= req_col;
                                        respOk_q            <= 1'b1;
                                    end else begin
                                        respOk_q <= 1'b0;
                                    end
                                end
                                OP_CANCEL: begin
                                    respValid_q <= 1'b1;
                                    if (hitFound) begin
                                        slotTime_q[hitIdx] <= 4'd0;
                                        respOk_q           <= 1'b1;
                                    end else begin
                                        respOk_q <= 1'b0;
                                    end
                                end
                                default: begin
                                    // CLEAR_ALL answers only when the sweep
                                    // finishes.
                                    slotTime_q <= '0;
                                    clrRow_q   <= 3'd0;
                                    clrCol_q   <= 4'd0;
                                    state_q    <= CLEARING;
                                end
                            endcase
                        end
                    end
                end
                CLEARING: begin
                    // Row-major sweep, one working cell per cycle.
                    workGrid_q[clrRow_q][clrCol_q] <= 4'd0;
                    if (clrCol_q == 4'd12) begin
                        clrCol_q <= 4'd0;
                        if (clrRow_q == 3'd7) begin
                            clrRow_q    <= 3'd0;
                            state_q     <= IDLE;
                            respValid_q <= 1'b1;
                            respOk_q    <= 1'b1;
                        end else begin
                            clrRow_q <= clrRow_q + 3'd1;
                        end
                    end else begin
                        clrCol_q <= clrCol_q + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule
